uart_cmd_parser: RTL
====================

// Module: uart_cmd_parser
// PURPOSE
//  Command-frame parser downstream of uart_byte_rx. Consumes its byte stream
//  (data + 1-cycle done strobe) and assembles 5-byte frames:
//  HEAD | ADDR | DATA_H | DATA_L | CSUM.
//  Emits a register-write request (addr, 16-bit data) on a valid frame.
//  Flags checksum errors and inter-byte timeouts. Feeds the register-bank / control logic.
// PARAMETERS
//  HEAD_BYTE    8'hAA   start-of-frame marker, matched only in S_IDLE
//  TIMEOUT_CYC  50000   max clk cycles between bytes inside a frame (1 ms @ 50 MHz)
// PORTS
//  clk           in   1   system clock, 50 MHz
//  rst           in   1   synchronous reset, active-high
//  i_RXD_Dout    in   8   received byte, valid when i_RXD_Done=1
//  i_RXD_Done    in   1   1-cycle strobe, one per received byte
//  o_PKT_Addr    out  8   address of last good frame
//  o_PKT_Data    out  16  data of last good frame, {DATA_H,DATA_L}
//  o_PKT_Valid   out  1   1-cycle pulse: o_PKT_Addr/o_PKT_Data updated
//  o_PKT_Err     out  1   1-cycle pulse: frame dropped
//  o_PKT_ErrCode out  2   01=checksum mismatch, 10=timeout; holds until next error
//  o_PKT_Cnt     out  8   count of good frames, wraps 255->0
//  o_PKT_Busy    out  1   1 while state != S_IDLE
// BEHAVIOUR
//  Reset (rst=1 at posedge clk):
//   - state=S_IDLE; timeout counter=0.
//   - All outputs 0, including o_PKT_Addr, o_PKT_Data, o_PKT_ErrCode and o_PKT_Cnt.
//   - Reset mid-frame discards the partial frame; no o_PKT_Err pulse.
//  FSM (advances only on i_RXD_Done=1):
//   - S_IDLE -> S_ADDR: only if byte==HEAD_BYTE; any other byte is ignored.
//   - S_ADDR -> S_DH -> S_DL -> S_CSUM: each transition latches its byte into a
//     shadow register.
//   - S_CSUM -> S_IDLE: compare the byte with csum = (ADDR+DATA_H+DATA_L) mod 256,
//     an 8-bit truncating sum.
//   - Match: next cycle o_PKT_Valid=1, outputs load from the shadow registers,
//     o_PKT_Cnt+1.
//   - Mismatch: next cycle o_PKT_Err=1, o_PKT_ErrCode=01. o_PKT_Addr, o_PKT_Data
//     and o_PKT_Cnt are unchanged.
//   - A HEAD_BYTE value inside a frame is plain data; there is no resync.
//  Latency:
//   - Valid/Err are registered: 1 cycle after the CSUM-byte strobe.
//   - They are never both high, and each is exactly 1 cycle wide.
//  Timeout:
//   - Counter clears on every i_RXD_Done and while in S_IDLE; it counts otherwise.
//   - When it reaches TIMEOUT_CYC-1 with no strobe: state returns to S_IDLE, and
//     next cycle o_PKT_Err=1, o_PKT_ErrCode=10.
//   - Counter width is $clog2(TIMEOUT_CYC).
//   - If a strobe coincides with expiry, the strobe wins: the byte is consumed
//     and there is no timeout.
//  Back-to-back frames:
//   - A HEAD_BYTE arriving in the cycle right after CSUM is accepted.
//   - No dead cycles are required.
//  o_PKT_Busy is combinational from state.
// TESTING
//  (bench: uart_byte_tx -> uart_byte_rx -> this block; Baud=4 (115200);
//   TIMEOUT_CYC=20000 for sim)
//  1. Send AA 12 34 56 9C -> one o_PKT_Valid pulse, Addr=8'h12, Data=16'h3456,
//     Cnt=1, Err never asserted.
//  2. Send AA 12 34 56 9D -> o_PKT_Err pulse, ErrCode=01; Addr/Data/Cnt keep
//     their prior values.
//  3. Send 00 55 AA 01 02 03 06 -> 00 and 55 are ignored; Valid, Addr=01,
//     Data=0203.
//  4. Send AA 01 and then idle for 25000 clk -> Err with ErrCode=10 after 20000
//     cycles, Busy falls. A following good frame is accepted.
//  5. Send AA AA AA AA 54 (AA+AA+AA=0x1FE -> 0xFE, mismatch) -> ErrCode=01.
//     Then AA AA AA AA FE -> Valid, Addr=AA, Data=AAAA.
//  6. Assert rst mid-frame (after AA 12) -> outputs 0, no Err. Then send
//     AA 12 34 56 9C -> Valid.
//     Also: 256 good frames -> Cnt wraps to 0.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and register-write request output of the command-frame parser.
`timescale 1ns/1ps
interface uart_cmd_parser_if;
    logic [7:0]  i_RXD_Dout;
    logic        i_RXD_Done;
    logic [7:0]  o_PKT_Addr;
    logic [15:0] o_PKT_Data;
    logic        o_PKT_Valid;
    logic        o_PKT_Err;
    logic [1:0]  o_PKT_ErrCode;
    logic [7:0]  o_PKT_Cnt;
    logic        o_PKT_Busy;

    // Byte source / consumer of write requests
    modport master (
        output i_RXD_Dout, i_RXD_Done,
        input  o_PKT_Addr, o_PKT_Data, o_PKT_Valid, o_PKT_Err,
               o_PKT_ErrCode, o_PKT_Cnt, o_PKT_Busy
    );

    // Parser side
    modport slave (
        input  i_RXD_Dout, i_RXD_Done,
        output o_PKT_Addr, o_PKT_Data, o_PKT_Valid, o_PKT_Err,
               o_PKT_ErrCode, o_PKT_Cnt, o_PKT_Busy
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Assembles HEAD|ADDR|DATA_H|DATA_L|CSUM frames from a received byte stream and
// issues register-write requests; flags checksum errors and inter-byte timeouts.
`timescale 1ns/1ps
module uart_cmd_parser #(
    parameter logic [7:0]  HEAD_BYTE   = 8'hAA,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic               clk,
    input  logic               rst,
    uart_cmd_parser_if.slave   bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DH,
        S_DL,
        S_CSUM
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] tmo_cnt;
    logic [7:0]       addr_sh;
    logic [7:0]       dh_sh;
    logic [7:0]       dl_sh;
    logic [7:0]       csum_c;
    logic             good_c;
    logic             csum_err_c;
    logic             tmo_c;

    // 8-bit truncating checksum over the shadowed payload
    assign csum_c = addr_sh + dh_sh + dl_sh;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and frame-result decode; a strobe always beats timeout expiry
    always_comb begin
        state_d    = state_q;
        good_c     = 1'b0;
        csum_err_c = 1'b0;
        tmo_c      = 1'b0;
        if (bus.i_RXD_Done) begin
            case (state_q)
                S_IDLE: if (bus.i_RXD_Dout == HEAD_BYTE) state_d = S_ADDR;
                S_ADDR: state_d = S_DH;
                S_DH:   state_d = S_DL;
                S_DL:   state_d = S_CSUM;
                S_CSUM: begin
                    state_d    = S_IDLE;
                    good_c     = (bus.i_RXD_Dout == csum_c);
                    csum_err_c = (bus.i_RXD_Dout != csum_c);
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && tmo_cnt == TMO_LAST) begin
            state_d = S_IDLE;
            tmo_c   = 1'b1;
        end
    end

    // Inter-byte timeout counter, idle outside frames
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (bus.i_RXD_Done || state_q == S_IDLE || tmo_c) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // Shadow registers for the frame payload
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_sh <= '0;
            dh_sh   <= '0;
            dl_sh   <= '0;
        end else if (bus.i_RXD_Done) begin
            case (state_q)
                S_ADDR:  addr_sh <= bus.i_RXD_Dout;
                S_DH:    dh_sh   <= bus.i_RXD_Dout;
                S_DL:    dl_sh   <= bus.i_RXD_Dout;
                default: ;
            endcase
        end
    end

    // Registered request/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.o_PKT_Addr    <= '0;
            bus.o_PKT_Data    <= '0;
            bus.o_PKT_Valid   <= 1'b0;
            bus.o_PKT_Err     <= 1'b0;
            bus.o_PKT_ErrCode <= '0;
            bus.o_PKT_Cnt     <= '0;
        end else begin
            bus.o_PKT_Valid <= good_c;
            bus.o_PKT_Err   <= csum_err_c | tmo_c;
            if (good_c) begin
                bus.o_PKT_Addr <= addr_sh;
                bus.o_PKT_Data <= {dh_sh, dl_sh};
                bus.o_PKT_Cnt  <= bus.o_PKT_Cnt + 8'd1;
            end
            if (csum_err_c) begin
                bus.o_PKT_ErrCode <= 2'b01;
            end else if (tmo_c) begin
                bus.o_PKT_ErrCode <= 2'b10;
            end
        end
    end

    // Frame-in-progress indicator
    assign bus.o_PKT_Busy = (state_q != S_IDLE);

endmodule
